// File: rtl/conv_sched_pkg.sv
// Shared geometry defaults, FSM encodings and derived-width helpers for the
// first convolution stage sequencer.
package conv_sched_pkg;

   localparam int DEF_IMG_W       = 8;
   localparam int DEF_IMG_H       = 8;
   localparam int DEF_K           = 3;
   localparam int DEF_NUM_FILTERS = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int out_dim(input int img, input int k);
      return img - k + 1;
   endfunction

   function automatic int npos(input int img_w, input int img_h, input int k);
      return out_dim(img_w, k) * out_dim(img_h, k);
   endfunction

   // A zero-width field is illegal, so a single value still gets one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int pos_width(input int img_w, input int img_h, input int k);
      return clog2_min1(npos(img_w, img_h, k));
   endfunction

   function automatic int filt_width(input int num_filters);
      return clog2_min1(num_filters);
   endfunction

endpackage

// File: rtl/conv_sched_delay.sv
// Valid/data shift register that tracks operations in flight through the
// MAC, adder tree and ReLU so the result write lines up with the data.
module conv_sched_delay
   import conv_sched_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          pending
);

   logic [DEPTH-1:0] vld;
   logic [DW-1:0]    dat [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
      end else begin
         vld[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
      end
   end

   // Payload needs no reset: it is only observed alongside its valid bit.
   always_ff @(posedge clk) begin
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
   end

   // Entries still to write after this cycle; the final stage writes now.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) pending = pending | vld[i];
   end

   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// Window/filter scan sequencer for the first convolution stage. Defining
// CONV_SCHED_PERF_EN adds saturating busy-cycle and stall counters.
module conv_sched
   import conv_sched_pkg::*;
#(
   parameter int IMG_W       = DEF_IMG_W,
   parameter int IMG_H       = DEF_IMG_H,
   parameter int K           = DEF_K,
   parameter int NUM_FILTERS = DEF_NUM_FILTERS,
   parameter int PIPE_LAT    = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 hold,
   output logic [$clog2(IMG_H)-1:0]             win_row,
   output logic [$clog2(IMG_W)-1:0]             win_col,
   output logic [filt_width(NUM_FILTERS)-1:0]   filt_sel,
   output logic                                 mac_valid,
   output logic                                 wr_en,
   output logic [filt_width(NUM_FILTERS)+pos_width(IMG_W, IMG_H, K)-1:0] wr_addr,
   output logic                                 busy,
   output logic                                 done
`ifdef CONV_SCHED_PERF_EN
   ,
   output logic [15:0]                          cyc_cnt,
   output logic [15:0]                          stall_cnt
`endif
);

   localparam int RW    = $clog2(IMG_H);
   localparam int CW    = $clog2(IMG_W);
   localparam int FW    = filt_width(NUM_FILTERS);
   localparam int PW    = pos_width(IMG_W, IMG_H, K);
   localparam int OUT_W = out_dim(IMG_W, K);
   localparam int OUT_H = out_dim(IMG_H, K);
   localparam int NPOS  = npos(IMG_W, IMG_H, K);

   localparam logic [RW-1:0] ROW_LAST  = RW'(OUT_H - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(OUT_W - 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(NUM_FILTERS - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(NPOS - 1);

   logic [1:0]    state;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [FW-1:0] filt;
   logic [PW-1:0] pos;
   logic          issue;
   logic          last;
   logic          pending;
   logic [FW+PW-1:0] dly_data;

   assign issue = (state == ST_RUN) && !hold;
   assign last  = (filt == FILT_LAST) && (row == ROW_LAST) && (col == COL_LAST);

   // Scan order is column fastest, then row, then filter; pos tracks
   // row*OUT_W+col incrementally so no multiplier is needed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         row   <= '0;
         col   <= '0;
         filt  <= '0;
         pos   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               row  <= '0;
               col  <= '0;
               filt <= '0;
               pos  <= '0;
               if (start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (issue) begin
                  pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
                  if (col == COL_LAST) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        row  <= '0;
                        filt <= (filt == FILT_LAST) ? '0 : filt + 1'b1;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
                  if (last) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: if (!pending) state <= ST_DONE;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   conv_sched_delay #(
      .DEPTH (PIPE_LAT),
      .DW    (FW + PW)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (issue),
      .in_data   ({filt, pos}),
      .out_valid (wr_en),
      .out_data  (dly_data),
      .pending   (pending)
   );

   assign win_row   = row;
   assign win_col   = col;
   assign filt_sel  = filt;
   assign mac_valid = issue;
   assign wr_addr   = wr_en ? dly_data : '0;
   assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);

`ifdef CONV_SCHED_PERF_EN
   // The accepting cycle counts as the first busy cycle of the pass.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt   <= '0;
         stall_cnt <= '0;
      end else if ((state == ST_IDLE) && start) begin
         cyc_cnt   <= 16'd1;
         stall_cnt <= '0;
      end else begin
         if (busy && (cyc_cnt != 16'hFFFF)) cyc_cnt <= cyc_cnt + 16'd1;
         if ((state == ST_RUN) && hold && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: expected issues and writes are queued per
// pass and popped by a negedge monitor; a second instance covers PIPE_LAT=1.
module tb_conv_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       hold = 1'b0;
   logic [2:0] win_row, win_col;
   logic [1:0] filt_sel;
   logic       mac_valid, wr_en, busy, done;
   logic [7:0] wr_addr;

   logic       start2 = 1'b0;
   logic [2:0] win_row2, win_col2;
   logic [0:0] filt_sel2;
   logic       mac_valid2, wr_en2, busy2, done2;
   logic [6:0] wr_addr2;

   int errors = 0;
   int checks = 0;
   int edges = 0;
   int base = 0;
   int mv_count, wr_count, done_count;
   int first_mv, last_mv, first_wr, last_wr;
   logic [7:0] exp_issue_q[$];
   logic [7:0] exp_addr_q[$];

   conv_sched u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .hold      (hold),
      .win_row   (win_row),
      .win_col   (win_col),
      .filt_sel  (filt_sel),
      .mac_valid (mac_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .busy      (busy),
      .done      (done)
   );

   conv_sched #(
      .NUM_FILTERS (1),
      .PIPE_LAT    (1)
   ) u_dut2 (
      .clk       (clk),
      .reset     (reset),
      .start     (start2),
      .hold      (1'b0),
      .win_row   (win_row2),
      .win_col   (win_col2),
      .filt_sel  (filt_sel2),
      .mac_valid (mac_valid2),
      .wr_en     (wr_en2),
      .wr_addr   (wr_addr2),
      .busy      (busy2),
      .done      (done2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      mv_count = 0; wr_count = 0; done_count = 0;
      first_mv = -1; last_mv = -1; first_wr = -1; last_wr = -1;
   endtask

   // Expected issue is {filt,row,col}; expected address is {filt, row*6+col}.
   task automatic push_pass();
      for (int f = 0; f < 3; f++)
         for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
               exp_issue_q.push_back({2'(f), 3'(r), 3'(c)});
               exp_addr_q.push_back({2'(f), 6'(r * 6 + c)});
            end
   endtask

   // Drives a one-cycle start pulse; the pulse cycle becomes cycle 0.
   task automatic apply_stimulus();
      step();
      start = 1'b1;
      base  = edges;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         step();
         if (done) begin
            at = edges - base;
            return;
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT issues or writes.
   always @(negedge clk) begin
      if (!reset) begin
         if (mac_valid) begin
            if (exp_issue_q.size() == 0) check_output("unexpected_issue", 1, 0);
            else check_output("issue", {filt_sel, win_row, win_col}, exp_issue_q.pop_front());
            if (mv_count == 7)  check_output("issue7", {filt_sel, win_row, win_col}, 8'b01_001);
            if (mv_count == 36) check_output("issue36", {filt_sel, win_row, win_col}, 8'b01_000_000);
            if (first_mv < 0) first_mv = edges - base;
            last_mv = edges - base;
            mv_count++;
         end
         if (wr_en) begin
            if (exp_addr_q.size() == 0) check_output("unexpected_write", 1, 0);
            else check_output("wr_addr", wr_addr, exp_addr_q.pop_front());
            if (wr_count == 7)  check_output("wr7", wr_addr, 8'h07);
            if (wr_count == 36) check_output("wr36", wr_addr, 8'h40);
            if (first_wr < 0) first_wr = edges - base;
            last_wr = edges - base;
            wr_count++;
         end
         if (done) begin
            done_count++;
            check_output("busy_at_done", busy, 0);
         end
      end
   end

   task automatic check_pass(input string tag, input int done_at, input int exp_done,
                             input int exp_last_mv, input int exp_last_wr);
      check_output({tag, "_done_cycle"}, done_at, exp_done);
      check_output({tag, "_first_mv"}, first_mv, 1);
      check_output({tag, "_last_mv"}, last_mv, exp_last_mv);
      check_output({tag, "_mv_count"}, mv_count, 108);
      check_output({tag, "_first_wr"}, first_wr, 3);
      check_output({tag, "_last_wr"}, last_wr, exp_last_wr);
      check_output({tag, "_wr_count"}, wr_count, 108);
      check_output({tag, "_queue_left"}, exp_addr_q.size(), 0);
   endtask

   initial begin
      int at;
      int saved_wr;
      int first2, last2, count2, done2_at;
      clear_stats();

      repeat (3) step();
      check_output("reset_outputs", {win_row, win_col, filt_sel, mac_valid, wr_en, wr_addr, busy, done}, 0);
      check_output("reset_outputs2", {win_row2, win_col2, filt_sel2, mac_valid2, wr_en2, wr_addr2, busy2, done2}, 0);
      reset = 1'b0;
      repeat (2) step();

      // Plain pass: issues 1..108, writes 3..110, done at 111.
      clear_stats();
      push_pass();
      apply_stimulus();
      check_output("busy_cycle1", busy, 1);
      wait_done(400, at);
      check_pass("plain", at, 111, 108, 110);
      step();
      check_output("idle_outputs", {win_row, win_col, filt_sel, busy, done}, 0);

      // Hold over cycles 10..19 stretches the pass by ten cycles.
      clear_stats();
      push_pass();
      apply_stimulus();
      repeat (9) step();
      hold = 1'b1;
      repeat (10) step();
      hold = 1'b0;
      wait_done(400, at);
      check_pass("hold", at, 121, 118, 120);
      repeat (2) step();

      // Reset mid-pass: everything clears, nothing more is written.
      clear_stats();
      push_pass();
      apply_stimulus();
      repeat (49) step();
      reset = 1'b1;
      step();
      exp_issue_q.delete();
      exp_addr_q.delete();
      check_output("abort_outputs", {win_row, win_col, filt_sel, mac_valid, wr_en, wr_addr, busy, done}, 0);
      reset = 1'b0;
      saved_wr = wr_count;
      repeat (30) step();
      check_output("abort_no_write", wr_count, saved_wr);
      check_output("abort_no_done", done_count, 0);

      clear_stats();
      push_pass();
      apply_stimulus();
      wait_done(400, at);
      check_pass("after_abort", at, 111, 108, 110);
      repeat (2) step();

      // Start held high: exactly one pass per IDLE entry.
      clear_stats();
      push_pass();
      push_pass();
      step();
      start = 1'b1;
      base  = edges;
      wait_done(400, at);
      check_output("held_done1", at, 111);
      wait_done(400, at);
      start = 1'b0;
      check_output("held_done2", at, 223);
      repeat (5) step();
      check_output("held_mv_count", mv_count, 216);
      check_output("held_last_mv", last_mv, 220);
      check_output("held_done_count", done_count, 2);
      check_output("held_idle", busy, 0);
      check_output("held_queue_left", exp_issue_q.size(), 0);

      // Single filter, one-cycle latency: writes 2..37, done at 38.
      first2 = -1; last2 = -1; count2 = 0; done2_at = -1;
      step();
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (wr_en2) begin
            if (first2 < 0) first2 = k;
            last2 = k;
            check_output("lat1_addr", wr_addr2, count2);
            count2++;
         end
         if (done2) done2_at = k;
         step();
      end
      check_output("lat1_first_wr", first2, 2);
      check_output("lat1_last_wr", last2, 37);
      check_output("lat1_wr_count", count2, 36);
      check_output("lat1_done", done2_at, 38);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
Sequencer for the first convolution stage (sliding 3x3 window, filter MAC, adder tree, ReLU, result BRAM).
- Scans every output position of every filter, one window per cycle.
- Drives the window position and filter select into the tensor window mux, the filter mux and the MAC path.
- Delays valid and address by the datapath latency to generate the result-BRAM write port.
- Handshakes start/done with the input-loading control unit and busy with the second stage.

Parameters:
IMG_W, 8, input tensor width
IMG_H, 8, input tensor height
K, 3, kernel size (square)
NUM_FILTERS, 3, filters applied in sequence
PIPE_LAT, 2, cycles from mac_valid to result valid at ReLU output (≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  tensor loaded; begin a full layer pass (pulse or level)
hold  in  1  downstream busy; suspend issuing new windows
win_row  out  $clog2(IMG_H)  top-left row of current window
win_col  out  $clog2(IMG_W)  top-left column of current window
filt_sel  out  max(1,$clog2(NUM_FILTERS))  filter select for filter/bias mux
mac_valid  out  1  window/filter presented this cycle is a real operation
wr_en  out  1  result BRAM write enable
wr_addr  out  FW+PW  result address = {filter, position}
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at pass completion

Behaviour:
- Interface: Clock clk; reset reset, synchronous, active-high.
- Derived widths and counts:
  - OUT_W = IMG_W-K+1 and OUT_H = IMG_H-K+1 (defaults 6, 6).
  - NPOS = OUT_W*OUT_H (36).
  - PW = $clog2(NPOS) (6); FW = filt_sel width (2).
- Reset: all outputs 0; state IDLE; counters and delay line cleared. Reset mid-pass aborts immediately: no further wr_en, and no done.
- FSM:
  - IDLE: start=1 → RUN; busy=1 from the next cycle.
  - RUN: each cycle with hold=0, issue one operation: mac_valid=1 with the current filt_sel, win_row and win_col.
    - Scan order: col fastest, then row, then filter.
    - pos = row*OUT_W+col, held in a dedicated counter; no multiplier.
    - hold=1: mac_valid=0 and counters frozen.
    - Issuing the last operation (filter NUM_FILTERS-1, row OUT_H-1, col OUT_W-1) → DRAIN.
  - DRAIN: no issue; wait until the delay line holds no valid entries → DONE.
  - DONE: done=1 for one cycle, busy=0 in this cycle, → IDLE.
- Issue outputs: win_row, win_col and filt_sel are registered and change only on issue. In IDLE they return to 0.
- Delay line: PIPE_LAT stages carrying {valid, filt, pos}.
  - wr_en and wr_addr equal stage PIPE_LAT-1.
  - wr_en = mac_valid delayed exactly PIPE_LAT cycles.
  - hold does not stall the delay line; writes in flight always complete.
- start is ignored outside IDLE.
- start=1 while in DONE is ignored; it is accepted in IDLE on the next cycle if still high.
- Counter wrap: col wraps OUT_W-1→0 with row++; row wraps OUT_H-1→0 with filter++. No counter ever exceeds its range.
- Timing without hold: start accepted at cycle 0 gives mac_valid at cycles 1..NUM_FILTERS*NPOS.

Optional Feature:
CONV_SCHED_PERF_EN
- Defined:
  - Two extra output ports: cyc_cnt[15:0] counts cycles with busy=1; stall_cnt[15:0] counts RUN cycles with hold=1.
  - Both counters saturate at 16'hFFFF.
  - Both clear on reset and on start acceptance, and hold their value after done.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package conv_sched_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Default geometry localparams (IMG_W, IMG_H, K, NUM_FILTERS).
  - Derived-width functions (OUT_W, NPOS, PW, FW).
- Sub-module conv_sched_delay: parameterised valid/data shift register, depth PIPE_LAT, width 1+FW+PW, synchronous reset of valid bits only.

Test Plan:
- Defaults, start pulse at cycle 0, hold=0:
  - mac_valid high at cycles 1..108.
  - wr_en high at cycles 3..110: first wr_addr=8'h00, last wr_addr=8'hA3.
  - done pulse at cycle 111, busy low at 111.
- Scan order: issue 7 (0-based) → filt_sel=0, win_row=1, win_col=1, later wr_addr=8'h07. Issue 36 → filt_sel=1, row=0, col=0, wr_addr=8'h40.
- hold=1 for cycles 10..19: exactly 108 wr_en pulses, done at cycle 121, no duplicate or skipped addresses. With PERF_EN defined: stall_cnt=10, cyc_cnt=121.
- reset=1 at cycle 50: all outputs 0 next cycle, no wr_en afterwards, no done. A new start then runs a full 108-write pass.
- start held high continuously: exactly one pass per IDLE entry. start during RUN or DRAIN is not re-latched, and no extra mac_valid appears mid-pass.
- PIPE_LAT=1 with NUM_FILTERS=1 at 8x8: 36 writes at cycles 2..37 and done at cycle 38.
